// File: rtl/joy_scan_if.sv
// Signal bundle between the joystick scan sequencer and its surroundings:
// trigger/enable in, serial chain pins, and the per-scan result word.
interface joy_scan_if #(
  parameter int NBITS = 16
);
  logic             enable;
  logic             frame_start;
  logic             joy_data;
  logic             joy_load_n;
  logic             joy_clk;
  logic             joy_sel;
  logic [NBITS-1:0] scan_word;
  logic [2:0]       scan_phase;
  logic             scan_valid;
  logic             busy;
  logic [1:0]       dbg_state;

  // scan_valid is a one-cycle qualifier with no ready: the consumer must take
  // scan_word/scan_phase in the cycle scan_valid is high; they hold afterwards.
  modport master (
    output enable, frame_start, joy_data,
    input  joy_load_n, joy_clk, joy_sel, scan_word, scan_phase, scan_valid,
           busy, dbg_state
  );

  modport slave (
    input  enable, frame_start, joy_data,
    output joy_load_n, joy_clk, joy_sel, scan_word, scan_phase, scan_valid,
           busy, dbg_state
  );
endinterface

// File: rtl/joy_scan_sequencer.sv
// Frame-triggered burst scanner for the daisy-chained joystick shift registers:
// drives load/clock/SELECT and emits one raw word per SELECT phase.
module joy_scan_sequencer #(
  parameter int CLK_DIV    = 4,
  parameter int NBITS      = 16,
  parameter int SEL_PHASES = 8,
  parameter int SETTLE     = 2
) (
  input logic      clk,
  input logic      reset,
  joy_scan_if.slave bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = (NBITS > SETTLE) ? $clog2(NBITS) : $clog2(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SHIFT  = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] div, div_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       phase, phase_d, done_phase;
  logic [NBITS-1:0] shreg, shreg_d;
  logic             pending, pending_d;
  logic             done, done_d;
  logic             period_end, sample;

  logic             load_n_q, load_n_d;
  logic             jclk_q, jclk_d;
  logic             sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [NBITS-1:0] word_q, word_d;
  logic [2:0]       sphase_q, sphase_d;

  assign period_end = (div == DIV_W'(CLK_DIV - 1));
  // Sample in the last low-clock cycle, just before the chain shifts.
  assign sample     = (state == S_SHIFT) && (div == DIV_W'(CLK_DIV / 2 - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      div        <= '0;
      cnt        <= '0;
      phase      <= '0;
      shreg      <= '1;
      pending    <= 1'b0;
      done       <= 1'b0;
      done_phase <= '0;
      load_n_q   <= 1'b1;
      jclk_q     <= 1'b0;
      sel_q      <= 1'b1;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      word_q     <= '1;
      sphase_q   <= '0;
    end else begin
      state      <= state_d;
      div        <= div_d;
      cnt        <= cnt_d;
      phase      <= phase_d;
      shreg      <= shreg_d;
      pending    <= pending_d;
      done       <= done_d;
      if (done_d) done_phase <= phase;
      load_n_q   <= load_n_d;
      jclk_q     <= jclk_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      word_q     <= word_d;
      sphase_q   <= sphase_d;
    end
  end

  always_comb begin
    state_d   = state;
    div_d     = period_end ? '0 : div + 1'b1;
    cnt_d     = cnt;
    phase_d   = phase;
    pending_d = pending;
    done_d    = 1'b0;
    shreg_d   = sample ? {shreg[NBITS-2:0], bus.joy_data} : shreg;

    unique case (state)
      S_IDLE: begin
        if (bus.enable && (bus.frame_start || pending)) begin
          state_d   = S_LOAD;
          phase_d   = '0;
          pending_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (period_end) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        if (period_end) begin
          if (cnt == CNT_W'(NBITS - 1)) begin
            done_d = 1'b1;
            // A dropped enable ends the burst here, after the scan in flight.
            if (bus.enable && (phase != 3'(SEL_PHASES - 1))) begin
              state_d = S_SETTLE;
              phase_d = phase + 3'd1;
              cnt_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else if (period_end) begin
          if (cnt == CNT_W'(SETTLE - 1)) state_d = S_LOAD;
          else cnt_d = cnt + 1'b1;
        end
      end
    endcase

    if ((state != S_IDLE) && bus.frame_start) pending_d = 1'b1;
    if (state_d != state) div_d = '0;
  end

  // Pin levels are computed from the next state so every output is a flop.
  always_comb begin
    load_n_d = (state_d != S_LOAD);
    jclk_d   = (state_d == S_SHIFT) && (div_d >= DIV_W'(CLK_DIV / 2));
    sel_d    = (state_d == S_IDLE) ? 1'b1 : ~phase_d[0];
    busy_d   = (state_d != S_IDLE);
    valid_d  = done;
    word_d   = done ? shreg : word_q;
    sphase_d = done ? done_phase : sphase_q;
  end

  assign bus.joy_load_n = load_n_q;
  assign bus.joy_clk    = jclk_q;
  assign bus.joy_sel    = sel_q;
  assign bus.scan_valid = valid_q;
  assign bus.scan_word  = word_q;
  assign bus.scan_phase = sphase_q;
  assign bus.busy       = busy_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_joy_scan_sequencer.sv
// Bench for joy_scan_sequencer: chain model, burst-level reference model with
// an expected-scan queue, a waveform table for one burst, and corner sequences.
module tb_joy_scan_sequencer;

  localparam int CLK_DIV    = 4;
  localparam int NBITS      = 16;
  localparam int SEL_PHASES = 8;
  localparam int SETTLE     = 2;
  localparam int SCAN_END   = CLK_DIV * (1 + NBITS);
  localparam int SPACING    = CLK_DIV * (1 + NBITS + SETTLE);
  localparam int W          = 32 + 3 + NBITS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  joy_scan_if #(.NBITS(NBITS)) bus ();

  joy_scan_sequencer #(
    .CLK_DIV(CLK_DIV), .NBITS(NBITS), .SEL_PHASES(SEL_PHASES), .SETTLE(SETTLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Joystick chain: parallel load while load_n low, shift on each joy_clk rise.
  logic [NBITS-1:0] word_hi = 16'hA5C3;
  logic [NBITS-1:0] word_lo = 16'h3C5A;
  logic [NBITS-1:0] chain = '1;
  logic             chain_prev_clk = 1'b0;
  assign bus.joy_data = chain[NBITS-1];

  always @(posedge clk) begin
    chain_prev_clk <= bus.joy_clk;
    if (!bus.joy_load_n) chain <= bus.joy_sel ? word_hi : word_lo;
    else if (bus.joy_clk && !chain_prev_clk) chain <= {chain[NBITS-2:0], 1'b1};
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_rise = 0;
  logic prev_jclk_s = 1'b0;

  logic [W-1:0] exp_q[$];
  bit m_busy = 1'b0;
  bit m_pend = 1'b0;
  int m_start = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Burst-level model: a burst started at edge s ends scan k at
  // s + SCAN_END + k*SPACING and reports it on the following cycle.
  task automatic model_step();
    int t, k;
    if (reset) begin
      m_busy = 1'b0;
      m_pend = 1'b0;
    end else if (!m_busy) begin
      if (bus.enable && (bus.frame_start || m_pend)) begin
        m_busy  = 1'b1;
        m_pend  = 1'b0;
        m_start = cyc;
      end
    end else begin
      if (bus.frame_start) m_pend = 1'b1;
      t = cyc - m_start;
      if (t >= SCAN_END && ((t - SCAN_END) % SPACING) == 0) begin
        k = (t - SCAN_END) / SPACING;
        exp_q.push_back({32'(cyc + 1), 3'(k), (k % 2 == 0) ? word_hi : word_lo});
        if (!bus.enable || k == SEL_PHASES - 1) m_busy = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    if (exp_q.size() > 0 && exp_q[0][W-1:W-32] == 32'(cyc)) begin
      e = exp_q.pop_front();
      chk("scan_valid", bus.scan_valid, 1);
      chk("scan_phase", bus.scan_phase, e[NBITS+2:NBITS]);
      chk("scan_word", bus.scan_word, e[NBITS-1:0]);
    end else begin
      chk("stray_scan_valid", bus.scan_valid, 0);
    end
    chk("busy", bus.busy, m_busy);
    if (!m_busy) begin
      chk("idle_sel", bus.joy_sel, 1);
      chk("idle_load_n", bus.joy_load_n, 1);
      chk("idle_joy_clk", bus.joy_clk, 0);
    end
    chk("load_clk_overlap", !bus.joy_load_n && bus.joy_clk, 0);
    if (bus.scan_valid) n_valid++;
    if (bus.joy_clk && !prev_jclk_s) n_rise++;
    prev_jclk_s = bus.joy_clk;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((m_busy || m_pend) && n < budget) begin
      tick();
      n++;
    end
    if (m_busy || m_pend) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles", budget);
    end
    tick();
  endtask

  typedef struct {
    int   off;
    logic load_n;
    logic jclk;
    logic sel;
    logic busy;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  initial begin
    int ti, n_load, first_v, k_load, v0;
    logic prev_ln, prev_j;

    // Pin levels at negedge after (trigger edge + off).
    tbl[0]  = '{0,   1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{3,   1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{4,   1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{5,   1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{6,   1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{7,   1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{8,   1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{67,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{68,  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{75,  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{76,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{79,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{80,  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{152, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{599, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{600, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{601, 1'b1, 1'b0, 1'b1, 1'b0};

    bus.enable      = 1'b0;
    bus.frame_start = 1'b0;

    // Reset state, then a quiet period with no trigger.
    reset = 1'b1;
    ticks(3);
    chk("rst_scan_word", bus.scan_word, 16'hFFFF);
    chk("rst_scan_phase", bus.scan_phase, 0);
    chk("rst_joy_sel", bus.joy_sel, 1);
    reset = 1'b0;
    bus.enable = 1'b1;
    v0 = n_valid;
    ticks(200);
    chk("quiet_valid_count", n_valid, v0);

    // One full burst against the waveform table.
    word_hi = 16'hA5C3;
    word_lo = 16'h3C5A;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    ti = 0; n_load = 0; first_v = -1; k_load = 0;
    prev_ln = 1'b1; prev_j = 1'b0; v0 = n_valid;
    for (int off = 0; off <= 601; off++) begin
      if (off > 0) tick();
      if (ti < NV && tbl[ti].off == off) begin
        chk($sformatf("tbl_load_n@%0d", off), bus.joy_load_n, tbl[ti].load_n);
        chk($sformatf("tbl_joy_clk@%0d", off), bus.joy_clk, tbl[ti].jclk);
        chk($sformatf("tbl_joy_sel@%0d", off), bus.joy_sel, tbl[ti].sel);
        chk($sformatf("tbl_busy@%0d", off), bus.busy, tbl[ti].busy);
        ti++;
      end
      if (off <= SCAN_END) begin
        if (!bus.joy_load_n) n_load++;
        if (bus.joy_clk && !prev_j) n_rise = n_rise;
      end
      if (off <= SCAN_END && bus.joy_clk && !prev_j) k_load = k_load;
      if (!bus.joy_load_n && prev_ln) begin
        chk($sformatf("sel_at_load%0d", k_load), bus.joy_sel, (k_load % 2) == 0);
        k_load++;
      end
      if (bus.scan_valid && first_v < 0) begin
        first_v = off;
        chk("first_word", bus.scan_word, 16'hA5C3);
      end
      prev_ln = bus.joy_load_n;
      prev_j  = bus.joy_clk;
    end
    chk("load_low_cycles", n_load, CLK_DIV);
    chk("first_valid_latency", first_v, 1 + SCAN_END);
    chk("loads_per_burst", k_load, SEL_PHASES);
    chk("burst_valid_count", n_valid - v0, SEL_PHASES);
    chk("table_rows_hit", ti, NV);

    // Shift clock rises in a single scan.
    wait_idle(2000);
    v0 = n_rise;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    ticks(SCAN_END);
    chk("joy_clk_rises_per_scan", n_rise - v0, NBITS);
    wait_idle(2000);

    // Three triggers during a burst collapse into one extra burst.
    word_hi = 16'h1234;
    word_lo = 16'hFEDC;
    v0 = n_valid;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    for (int off = 1; off <= 1300; off++) begin
      bus.frame_start = (off == 100 || off == 250 || off == 400);
      tick();
      bus.frame_start = 1'b0;
      if (off == 600) chk("collide_idle_at_600", bus.busy, 0);
      if (off == 601) chk("collide_restart_at_601", bus.busy, 1);
    end
    chk("collide_valid_count", n_valid - v0, 2 * SEL_PHASES);
    wait_idle(2000);

    // Enable dropped during phase 3 SHIFT, with a pending trigger.
    word_hi = 16'h0F0F;
    word_lo = 16'hC001;
    v0 = n_valid;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    for (int off = 1; off <= 400; off++) begin
      bus.frame_start = (off == 100);
      if (off == 3 * SPACING + 30) bus.enable = 1'b0;
      tick();
      bus.frame_start = 1'b0;
    end
    chk("endrop_valid_count", n_valid - v0, 4);
    chk("endrop_busy", bus.busy, 0);
    chk("endrop_sel", bus.joy_sel, 1);
    chk("endrop_last_phase", bus.scan_phase, 3);
    ticks(50);
    chk("endrop_held_idle", bus.busy, 0);
    bus.enable = 1'b1;
    tick();
    chk("endrop_pending_start", bus.busy, 1);
    ticks(SCAN_END + 1);
    chk("endrop_restart_phase", bus.scan_phase, 0);
    wait_idle(2000);

    // Reset during the SETTLE that follows phase 5.
    v0 = n_valid;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    ticks(SCAN_END + 5 * SPACING + 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_load_n", bus.joy_load_n, 1);
    chk("mrst_joy_clk", bus.joy_clk, 0);
    chk("mrst_joy_sel", bus.joy_sel, 1);
    chk("mrst_scan_word", bus.scan_word, 16'hFFFF);
    chk("mrst_scan_phase", bus.scan_phase, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_valid_before", n_valid - v0, 6);
    v0 = n_valid;
    n_rise = 0;
    ticks(300);
    chk("mrst_no_valid_after", n_valid - v0, 0);
    chk("mrst_no_clk_edge", n_rise, 0);

    // Random triggers and chain contents against the model.
    for (int r = 0; r < 4; r++) begin
      word_hi = 16'($urandom);
      word_lo = 16'($urandom);
      for (int i = 0; i < 1500; i++) begin
        bus.frame_start = ($urandom_range(0, 199) == 0);
        tick();
      end
      bus.frame_start = 1'b0;
      wait_idle(2000);
    end

    ticks(5);
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      checks++;
      errors++;
      $display("FAIL missing_scan_valid: expected scan never reported");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/joy_scan_sequencer.md
Name: joy_scan_sequencer

Overview:
- Scan controller for the twin-joystick serial input chain: parallel-load shift register with daisy-chained ports, plus a Sega-style SELECT line shared by both ports.
- Owns the complete read sequence: load strobe, shift clock, SELECT toggling and serial sampling. It replaces free-running, hsync-locked scanning with deterministic, frame-triggered bursts.
- Each burst runs SEL_PHASES scans with alternating SELECT. Each scan outputs one raw word with a phase index, for the downstream 3/6-button decode FSMs.

Parameters:
- CLK_DIV, 4, clk cycles per bit period; must be even and at least 4.
- NBITS, 16, serial bits per scan, covering both ports.
- SEL_PHASES, 8, scans per burst; must be between 2 and 8.
- SETTLE, 2, bit periods of wait after each SELECT change before the next load.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scanning permitted.
- frame_start  in  1  single-cycle burst trigger (e.g. per video frame).
- joy_data  in  1  serial data from the chain, already synchronised.
- joy_load_n  out  1  active-low parallel-load strobe.
- joy_clk  out  1  shift clock.
- joy_sel  out  1  Sega SELECT line to both ports.
- scan_word  out  NBITS  last captured word; the first bit received lands in the MSB.
- scan_phase  out  3  burst phase (0..SEL_PHASES-1) of scan_word.
- scan_valid  out  1  one-cycle pulse when scan_word and scan_phase update.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: joy_load_n=1, joy_clk=0, joy_sel=1, scan_word all ones, scan_phase=0, scan_valid=0, busy=0, pending=0, state IDLE.
- Bit-period counter div runs 0..CLK_DIV-1 in every non-IDLE state and is cleared on each state entry. Each state lasts a whole number of periods.
- FSM states: IDLE, LOAD, SHIFT, SETTLE.
- IDLE:
  - Outputs are held at reset levels, except scan_word and scan_phase, which keep their last values.
  - If enable and (frame_start or pending) are high at a clk edge: phase=0, joy_sel=1, pending cleared, and the next cycle starts LOAD.
- LOAD: one bit period with joy_load_n=0 and joy_clk=0, then SHIFT with bit index 0.
- SHIFT: NBITS bit periods.
  - joy_clk=0 for div < CLK_DIV/2 and 1 otherwise, giving exactly NBITS rising edges per scan.
  - joy_data is sampled at div=CLK_DIV/2-1, just before the rising edge, into shift bit NBITS-1-index.
  - After the last period, in the following cycle: scan_word gets the captured word, scan_phase=phase, and scan_valid pulses for 1 cycle.
  - scan_valid therefore rises 1+CLK_DIV*(1+NBITS) cycles after the triggering edge.
- After SHIFT:
  - If phase < SEL_PHASES-1: phase+1, joy_sel toggles (so joy_sel = ~phase[0]), then SETTLE.
  - Otherwise: joy_sel=1 and return to IDLE.
- SETTLE: SETTLE bit periods with joy_load_n=1 and joy_clk=0, then LOAD.
- frame_start while busy: sets pending. The current burst is never aborted or restarted. Pending starts a new burst from IDLE in the cycle after returning, if enable is high. Multiple triggers collapse into one.
- enable low outside IDLE: the current scan, SHIFT included, completes and emits its scan_valid. The FSM then returns to IDLE with joy_sel=1, skipping SETTLE. pending is kept.
- reset mid-burst: all outputs return to reset values in the next cycle. No scan_valid is emitted for the partial scan, and pending is cleared.
- joy_load_n and joy_clk are never low and high at the same time. joy_sel changes only while joy_load_n=1 and joy_clk=0.
- All outputs are registered and glitch-free; no combinational path runs from inputs to outputs.

Test Plan:
- Reset: assert reset for 3 cycles -> joy_load_n=1, joy_clk=0, joy_sel=1, scan_word=16'hFFFF, busy=0; no scan_valid for 200 cycles with frame_start low.
- Single scan (CLK_DIV=4, NBITS=16): model the chain with 16'hA5C3 and pulse frame_start -> joy_load_n low for exactly 4 cycles, 16 joy_clk rises, first scan_valid 69 cycles after the trigger edge with scan_word=16'hA5C3 and scan_phase=0.
- Full burst (SEL_PHASES=8, SETTLE=2): chain returns a different word per SELECT level -> 8 scan_valid pulses with phases 0..7 and matching words. Spacing is (1+16+2)*4=76 cycles. joy_sel reads 1,0,1,0,... at each load and ends at 1 with busy=0.
- Trigger collision: pulse frame_start 3 times during a burst -> exactly one extra burst, starting 1 cycle after IDLE is re-entered.
- Enable drop: deassert enable during phase 3 SHIFT -> phase 3 completes with its scan_valid, there is no phase 4, and joy_sel=1 in IDLE. Reasserting enable with pending set starts a burst at phase 0.
- Mid-burst reset: assert reset during phase 5 SETTLE -> next cycle shows reset values, no stray joy_clk edge, and no further scan_valid without a new frame_start.
